reset_seq: RTL and testbench

- Reset generator and sequencer: the issuing side of the reset path, complementing the per-domain reset synchronizers that consume its outputs.
- Holds all outputs in reset for a minimum time, then releases them one after another, in index order, with a fixed stagger between releases.
- Sources: power-on reset (reset_n), software reset request with 4-phase req/ack handshake, and optional watchdog expiry.
- Sits at top level; reset_out bits drive downstream reset synchronizers or subsystem resets.

---
 rtl/reset_seq.sv | 138 +++++++++++++
 tb/tb_reset_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/reset_seq.sv
// Reset generator/sequencer: holds all resets, then releases them in index order with a stagger.
// Optional watchdog source enabled by defining RESET_SEQ_WDT_EN.
module reset_seq #(
  parameter int unsigned NumOutputs    = 3,
  parameter int unsigned HoldCycles    = 16,
  parameter int unsigned StaggerCycles = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sw_reset_req,
  output logic                  sw_reset_ack,
  input  logic                  wdt_expire,
  output logic [NumOutputs-1:0] reset_out,
  output logic                  busy,
  output logic [1:0]            reset_cause
);

  localparam int unsigned MaxCycles = (HoldCycles > StaggerCycles) ? HoldCycles : StaggerCycles;
  localparam int unsigned CntW      = $clog2(MaxCycles) + 1;
  localparam int unsigned IdxW      = (NumOutputs > 1) ? $clog2(NumOutputs) : 1;

  typedef enum logic [1:0] {HOLD, RELEASE, IDLE} state_t;

  state_t                state, state_n;
  logic [CntW-1:0]       cnt, cnt_n;
  logic [IdxW-1:0]       idx, idx_n;
  logic [NumOutputs-1:0] out_n;
  logic                  busy_n, ack_n;
  logic [1:0]            cause_n;
  // sw_taken: request consumed, blocks retrigger until req is seen low.
  // sw_seq: current sequence was started by a software request.
  logic                  sw_taken, sw_taken_n;
  logic                  sw_seq, sw_seq_n;
  logic                  sw_event, wdt_event;

`ifdef RESET_SEQ_WDT_EN
  assign wdt_event = wdt_expire;
`else
  logic unused_wdt;
  assign unused_wdt = wdt_expire;
  assign wdt_event  = 1'b0;
`endif

  assign sw_event = sw_reset_req && !sw_reset_ack && !sw_taken;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= HOLD;
      cnt          <= '0;
      idx          <= '0;
      reset_out    <= '1;
      busy         <= 1'b1;
      sw_reset_ack <= 1'b0;
      reset_cause  <= 2'b00;
      sw_taken     <= 1'b0;
      sw_seq       <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      idx          <= idx_n;
      reset_out    <= out_n;
      busy         <= busy_n;
      sw_reset_ack <= ack_n;
      reset_cause  <= cause_n;
      sw_taken     <= sw_taken_n;
      sw_seq       <= sw_seq_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    idx_n      = idx;
    out_n      = reset_out;
    busy_n     = busy;
    ack_n      = sw_reset_ack;
    cause_n    = reset_cause;
    sw_taken_n = sw_taken;
    sw_seq_n   = sw_seq;

    if (!sw_reset_req) begin
      ack_n      = 1'b0;
      sw_taken_n = 1'b0;
    end

    if (sw_event || wdt_event) begin
      out_n    = '1;
      busy_n   = 1'b1;
      cnt_n    = '0;
      idx_n    = '0;
      state_n  = HOLD;
      cause_n  = wdt_event ? 2'b10 : 2'b01;
      sw_seq_n = sw_event;
      if (sw_event) sw_taken_n = 1'b1;
    end else begin
      case (state)
        HOLD: begin
          if (cnt == CntW'(HoldCycles - 1)) begin
            out_n[0] = 1'b0;
            cnt_n    = '0;
            if (NumOutputs == 1) begin
              state_n  = IDLE;
              busy_n   = 1'b0;
              sw_seq_n = 1'b0;
              if (sw_seq && sw_reset_req) ack_n = 1'b1;
            end else begin
              idx_n   = IdxW'(1);
              state_n = RELEASE;
            end
          end else begin
            cnt_n = cnt + CntW'(1);
          end
        end
        RELEASE: begin
          if (cnt == CntW'(StaggerCycles - 1)) begin
            out_n[idx] = 1'b0;
            cnt_n      = '0;
            if (idx == IdxW'(NumOutputs - 1)) begin
              state_n  = IDLE;
              busy_n   = 1'b0;
              sw_seq_n = 1'b0;
              if (sw_seq && sw_reset_req) ack_n = 1'b1;
            end else begin
              idx_n = idx + IdxW'(1);
            end
          end else begin
            cnt_n = cnt + CntW'(1);
          end
        end
        default: begin
          out_n  = '0;
          busy_n = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_seq.sv
// Bench for reset_seq: vector table, hand-written corner sequences and random traffic
// checked against a time-since-event reference model.
module tb_reset_seq;

  localparam int NUM  = 3;
  localparam int HOLD = 16;
  localparam int STAG = 4;
  localparam int LAST = HOLD + (NUM - 1) * STAG;

`ifdef RESET_SEQ_WDT_EN
  localparam bit WDT_EN = 1'b1;
`else
  localparam bit WDT_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           req = 1'b0;
  logic           wdt = 1'b0;
  logic           ack;
  logic [NUM-1:0] rout;
  logic           busy;
  logic [1:0]     cause;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model: edges since the last reset event plus handshake flags
  int       m_t;
  bit       m_busy, m_ack, m_taken, m_seq;
  bit [1:0] m_cause;

  reset_seq #(.NumOutputs(NUM), .HoldCycles(HOLD), .StaggerCycles(STAG)) dut (
    .clk(clk), .reset_n(rst_n), .sw_reset_req(req), .sw_reset_ack(ack),
    .wdt_expire(wdt), .reset_out(rout), .busy(busy), .reset_cause(cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        wdt;
    int unsigned n;
    logic [2:0]  out;
    logic        busy;
    logic        ack;
    logic [1:0]  cause;
  } vec_t;

  vec_t tbl[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_busy = 1; m_ack = 0; m_taken = 0; m_seq = 0; m_cause = 2'b00;
  endtask

  function automatic logic [NUM-1:0] model_out();
    logic [NUM-1:0] v;
    for (int k = 0; k < NUM; k++) v[k] = m_busy && (m_t < HOLD + k * STAG);
    return v;
  endfunction

  task automatic model_edge();
    bit sw_ev, wdt_ev;
    if (!rst_n) begin
      model_reset();
      return;
    end
    sw_ev  = req && !m_ack && !m_taken;
    wdt_ev = WDT_EN && wdt;
    if (!req) begin
      m_ack = 0;
      m_taken = 0;
    end
    if (sw_ev || wdt_ev) begin
      m_t = 0;
      m_busy = 1;
      m_cause = wdt_ev ? 2'b10 : 2'b01;
      m_seq = sw_ev;
      if (sw_ev) m_taken = 1;
    end else if (m_busy) begin
      m_t++;
      if (m_t == LAST) begin
        m_busy = 0;
        if (m_seq && req) m_ack = 1;
        m_seq = 0;
      end
    end
  endtask

  task automatic compare_model();
    check("model_out", 32'(rout), 32'(model_out()));
    check("model_busy", 32'(busy), 32'(m_busy));
    check("model_ack", 32'(ack), 32'(m_ack));
    check("model_cause", 32'(cause), 32'(m_cause));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic expect_now(input string name, input logic [2:0] o, input logic b,
                            input logic a, input logic [1:0] c);
    check({name, "_out"}, 32'(rout), 32'(o));
    check({name, "_busy"}, 32'(busy), 32'(b));
    check({name, "_ack"}, 32'(ack), 32'(a));
    check({name, "_cause"}, 32'(cause), 32'(c));
  endtask

  initial begin
    // POR release
    tbl[0]  = '{1'b0, 1'b0, 15, 3'b111, 1'b1, 1'b0, 2'b00};
    tbl[1]  = '{1'b0, 1'b0,  1, 3'b110, 1'b1, 1'b0, 2'b00};
    tbl[2]  = '{1'b0, 1'b0,  4, 3'b100, 1'b1, 1'b0, 2'b00};
    tbl[3]  = '{1'b0, 1'b0,  4, 3'b000, 1'b0, 1'b0, 2'b00};
    // software request with handshake, req held past ack
    tbl[4]  = '{1'b1, 1'b0,  1, 3'b111, 1'b1, 1'b0, 2'b01};
    tbl[5]  = '{1'b1, 1'b0, 15, 3'b111, 1'b1, 1'b0, 2'b01};
    tbl[6]  = '{1'b1, 1'b0,  1, 3'b110, 1'b1, 1'b0, 2'b01};
    tbl[7]  = '{1'b1, 1'b0,  4, 3'b100, 1'b1, 1'b0, 2'b01};
    tbl[8]  = '{1'b1, 1'b0,  4, 3'b000, 1'b0, 1'b1, 2'b01};
    tbl[9]  = '{1'b1, 1'b0,  5, 3'b000, 1'b0, 1'b1, 2'b01};
    tbl[10] = '{1'b0, 1'b0,  1, 3'b000, 1'b0, 1'b0, 2'b01};
    // second request after bit0 released restarts the full hold
    tbl[11] = '{1'b1, 1'b0, 17, 3'b110, 1'b1, 1'b0, 2'b01};
    tbl[12] = '{1'b0, 1'b0,  1, 3'b110, 1'b1, 1'b0, 2'b01};
    tbl[13] = '{1'b1, 1'b0,  1, 3'b111, 1'b1, 1'b0, 2'b01};
    tbl[14] = '{1'b1, 1'b0, 23, 3'b100, 1'b1, 1'b0, 2'b01};
    tbl[15] = '{1'b1, 1'b0,  1, 3'b000, 1'b0, 1'b1, 2'b01};
    tbl[16] = '{1'b0, 1'b0,  1, 3'b000, 1'b0, 1'b0, 2'b01};

    model_reset();
    #2 rst_n = 1'b0;
    #1 expect_now("por_async", 3'b111, 1'b1, 1'b0, 2'b00);
    repeat (5) step();
    expect_now("por_held", 3'b111, 1'b1, 1'b0, 2'b00);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      req = tbl[i].req;
      wdt = tbl[i].wdt;
      repeat (tbl[i].n) step();
      expect_now($sformatf("vec%0d", i), tbl[i].out, tbl[i].busy, tbl[i].ack, tbl[i].cause);
    end

`ifdef RESET_SEQ_WDT_EN
    wdt = 1'b1;
    step();
    expect_now("wdt_event", 3'b111, 1'b1, 1'b0, 2'b10);
    wdt = 1'b0;
    repeat (LAST) step();
    expect_now("wdt_done", 3'b000, 1'b0, 1'b0, 2'b10);
    req = 1'b1; wdt = 1'b1;
    step();
    expect_now("both_event", 3'b111, 1'b1, 1'b0, 2'b10);
    wdt = 1'b0;
    repeat (LAST) step();
    expect_now("both_done", 3'b000, 1'b0, 1'b1, 2'b10);
    req = 1'b0;
    step();
    expect_now("both_ackfall", 3'b000, 1'b0, 1'b0, 2'b10);
`else
    wdt = 1'b1;
    step();
    expect_now("wdt_ignored", 3'b000, 1'b0, 1'b0, 2'b01);
    wdt = 1'b0;
    repeat (3) step();
    expect_now("wdt_ignored2", 3'b000, 1'b0, 1'b0, 2'b01);
`endif

    // async abort after bit1 released
    req = 1'b1;
    step();
    repeat (HOLD + STAG) step();
    expect_now("pre_abort", 3'b100, 1'b1, 1'b0, 2'b01);
    req = 1'b0;
    #2 rst_n = 1'b0;
    #1 expect_now("abort_async", 3'b111, 1'b1, 1'b0, 2'b00);
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (LAST - 1) step();
    expect_now("abort_almost", 3'b100, 1'b1, 1'b0, 2'b00);
    step();
    expect_now("abort_done", 3'b000, 1'b0, 1'b0, 2'b00);

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(39) == 0) req = ~req;
      wdt = ($urandom_range(199) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
